// File: rtl/hsi_to_rgb_winpaint.sv
// hsi_to_rgb_winpaint
//   Converts Windows-Paint scaled HSI (H 0..239, S 0..240, I 0..240) back to
//   8-bit RGB. Fully pipelined, one pixel per clock, fixed latency of 6 clocks
//   from the edge that samples HSIinEn=1 to the edge that raises RGBoutEn.
//   Out-of-range inputs are clamped (H to 239, S and I to 240).
//
// Optional feature macro: HSI2RGB_RANGE_CHECK_EN
//   When defined, adds RangeErr, high alongside RGBoutEn for a pixel whose
//   raw input was out of range.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   Hin       in   [7:0] hue, 40 counts per sector
//   Sin       in   [7:0] saturation
//   Iin       in   [7:0] intensity
//   HSIinEn   in   input valid
//   R,G,B     out  [7:0] colour channels, held while RGBoutEn=0
//   RGBoutEn  out  output valid
//   RangeErr  out  out-of-range flag (HSI2RGB_RANGE_CHECK_EN only)
//
// Pipeline ranks
//   0: input capture   1: clamp, |2I-240|, sector k, offset g
//   2: Cw              3: mw, (Cw*g)>>3
//   4: Xw, sector mux  5: (c+mw)*255+28800, pre-shifted by 8
//   6: /225, output registers
module hsi_to_rgb_winpaint #(
  parameter int LATENCY = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Hin,
  input  logic [7:0] Sin,
  input  logic [7:0] Iin,
  input  logic       HSIinEn,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       RGBoutEn
`ifdef HSI2RGB_RANGE_CHECK_EN
  ,
  output logic       RangeErr
`endif
);

  localparam int STAGES = 6;

  if (LATENCY != STAGES) begin : g_lat_chk
    $error("hsi_to_rgb_winpaint: LATENCY must be 6");
  end

  logic [STAGES:0] r_vld_pipe;

  // rank 0
  logic [7:0] r0_h, r0_s, r0_i;
  // rank 1
  logic [7:0] w1_h, w1_s, w1_i, w1_ad;
  logic [2:0] w1_k;
  logic [5:0] w1_f, w1_g;
  logic [7:0] r1_ad, r1_s, r1_i;
  logic [2:0] r1_k;
  logic [5:0] r1_g;
  // rank 2
  logic [7:0]  w2_cc;
  logic [15:0] w2_cw;
  logic [15:0] r2_cw;
  logic [7:0]  r2_i;
  logic [2:0]  r2_k;
  logic [5:0]  r2_g;
  // rank 3
  logic [15:0] w3_mw;
  logic [18:0] w3_cwy;
  logic [15:0] r3_cw, r3_mw;
  logic [18:0] r3_cwy;
  logic [2:0]  r3_k;
  // rank 4, channel index 2=R 1=G 0=B
  logic [15:0]       w4_xw;
  logic [2:0][15:0]  w4_c;
  logic [2:0][15:0]  r4_c;
  logic [15:0]       r4_mw;
  // rank 5
  logic [2:0][15:0]  w5_q, r5_q;
  // rank 6
  logic [2:0][7:0]   w6_o;

  // ---------------- rank 1 combinational ----------------
  assign w1_h = (r0_h > 8'd239) ? 8'd239 : r0_h;
  assign w1_s = (r0_s > 8'd240) ? 8'd240 : r0_s;
  assign w1_i = (r0_i > 8'd240) ? 8'd240 : r0_i;

  assign w1_ad = (w1_i >= 8'd120) ? 8'({w1_i, 1'b0} - 9'd240)
                                  : 8'(9'd240 - {w1_i, 1'b0});

  // Sector by compare chain; f is always < 40 so 6 bits of the difference suffice.
  always_comb begin
    w1_k = 3'd5;
    w1_f = 6'(w1_h - 8'd200);
    if (w1_h < 8'd40) begin
      w1_k = 3'd0;
      w1_f = w1_h[5:0];
    end else if (w1_h < 8'd80) begin
      w1_k = 3'd1;
      w1_f = 6'(w1_h - 8'd40);
    end else if (w1_h < 8'd120) begin
      w1_k = 3'd2;
      w1_f = 6'(w1_h - 8'd80);
    end else if (w1_h < 8'd160) begin
      w1_k = 3'd3;
      w1_f = 6'(w1_h - 8'd120);
    end else if (w1_h < 8'd200) begin
      w1_k = 3'd4;
      w1_f = 6'(w1_h - 8'd160);
    end
  end

  // Odd sectors ramp down, even sectors ramp up.
  assign w1_g = w1_k[0] ? 6'(6'd40 - w1_f) : w1_f;

  // ---------------- rank 2..6 combinational ----------------
  assign w2_cc = 8'd240 - r1_ad;
  assign w2_cw = {8'd0, w2_cc} * {8'd0, r1_s};

  assign w3_mw  = 16'(16'(r2_i) * 16'd240) - {1'b0, r2_cw[15:1]};
  // Cw*g/40 = ((Cw*g)>>3)/5; the >>3 happens here to keep the register narrow.
  assign w3_cwy = 19'((22'(r2_cw) * 22'(r2_g)) >> 3);

  // y/5 == (y*419431)>>21 exactly for y < 699050; y here is below 288001.
  assign w4_xw = 16'((37'(r3_cwy) * 37'd419431) >> 21);

  always_comb begin
    w4_c = '0;
    case (r3_k)
      3'd0:    w4_c = {r3_cw, w4_xw, 16'd0};
      3'd1:    w4_c = {w4_xw, r3_cw, 16'd0};
      3'd2:    w4_c = {16'd0, r3_cw, w4_xw};
      3'd3:    w4_c = {16'd0, w4_xw, r3_cw};
      3'd4:    w4_c = {w4_xw, 16'd0, r3_cw};
      3'd5:    w4_c = {r3_cw, 16'd0, w4_xw};
      default: w4_c = '0;
    endcase
  end

  // 57600 = 256*225: drop 8 bits here (exact for floor), divide by 225 next rank.
  always_comb begin
    for (int c = 0; c < 3; c++)
      w5_q[c] = 16'((((24'(r4_c[c]) + 24'(r4_mw)) * 24'd255) + 24'd28800) >> 8);
  end

  // q/225 == (q*74566)>>24 exactly for q < 125203; q here is at most 57487.
  always_comb begin
    for (int c = 0; c < 3; c++)
      w6_o[c] = 8'((33'(r5_q[c]) * 33'd74566) >> 24);
  end

  // ---------------- datapath registers (qualified by valid bits) ----------------
  always_ff @(posedge clk) begin
    r0_h  <= Hin;
    r0_s  <= Sin;
    r0_i  <= Iin;
    r1_ad <= w1_ad;
    r1_s  <= w1_s;
    r1_i  <= w1_i;
    r1_k  <= w1_k;
    r1_g  <= w1_g;
    r2_cw <= w2_cw;
    r2_i  <= r1_i;
    r2_k  <= r1_k;
    r2_g  <= r1_g;
    r3_cw  <= r2_cw;
    r3_mw  <= w3_mw;
    r3_cwy <= w3_cwy;
    r3_k   <= r2_k;
    r4_c  <= w4_c;
    r4_mw <= r3_mw;
    r5_q  <= w5_q;
  end

  // ---------------- valid pipe and outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      R <= 8'd0;
      G <= 8'd0;
      B <= 8'd0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], HSIinEn};
      if (r_vld_pipe[STAGES-1]) begin
        R <= w6_o[2];
        G <= w6_o[1];
        B <= w6_o[0];
      end
    end
  end

  assign RGBoutEn = r_vld_pipe[STAGES];

`ifdef HSI2RGB_RANGE_CHECK_EN
  logic             w1_err;
  logic [STAGES-1:1] r_err_pipe;

  assign w1_err = (r0_h > 8'd239) | (r0_s > 8'd240) | (r0_i > 8'd240);

  always_ff @(posedge clk) begin
    r_err_pipe <= {r_err_pipe[STAGES-2:1], w1_err};
  end

  always_ff @(posedge clk) begin
    if (rst) RangeErr <= 1'b0;
    else     RangeErr <= r_vld_pipe[STAGES-1] & r_err_pipe[STAGES-1];
  end
`endif

endmodule

// File: tb/tb_hsi_to_rgb_winpaint.sv
// Directed bench for hsi_to_rgb_winpaint. Inputs are driven and outputs
// sampled on the falling edge. A reference delay line (6 entries plus an
// output register) tracks valid/hold/reset behaviour; pixel colours come from
// hand-computed constants or from the integer formulas written out directly.
module tb_hsi_to_rgb_winpaint;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Hin, Sin, Iin;
  logic       HSIinEn;
  logic [7:0] R, G, B;
  logic       RGBoutEn;
`ifdef HSI2RGB_RANGE_CHECK_EN
  logic       RangeErr;
`endif

  int n_run  = 0;
  int n_fail = 0;
  int cycn   = 0;

  always #5 clk = ~clk;

  hsi_to_rgb_winpaint #(.LATENCY(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .Hin      (Hin),
    .Sin      (Sin),
    .Iin      (Iin),
    .HSIinEn  (HSIinEn),
    .R        (R),
    .G        (G),
    .B        (B),
    .RGBoutEn (RGBoutEn)
`ifdef HSI2RGB_RANGE_CHECK_EN
    ,
    .RangeErr (RangeErr)
`endif
  );

  typedef struct packed {
    logic       v;
    logic       e;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  exp_t mline [6];
  exp_t outm;

  function automatic logic [7:0] ch(input int c);
    return 8'((c * 255 + 28800) / 57600);
  endfunction

  function automatic logic [23:0] model(input int h, input int s, input int i);
    int hc, sc, ic, d, cw, mw, k, f, g, xw, cr, cg, cb;
    hc = (h > 239) ? 239 : h;
    sc = (s > 240) ? 240 : s;
    ic = (i > 240) ? 240 : i;
    d  = 2 * ic - 240;
    if (d < 0) d = -d;
    cw = (240 - d) * sc;
    mw = 240 * ic - cw / 2;
    k  = hc / 40;
    f  = hc - 40 * k;
    g  = (k % 2 == 0) ? f : 40 - f;
    xw = (cw * g) / 40;
    cr = 0; cg = 0; cb = 0;
    case (k)
      0: begin cr = cw; cg = xw; end
      1: begin cr = xw; cg = cw; end
      2: begin cg = cw; cb = xw; end
      3: begin cg = xw; cb = cw; end
      4: begin cr = xw; cb = cw; end
      default: begin cr = cw; cb = xw; end
    endcase
    return {ch(cr + mw), ch(cg + mw), ch(cb + mw)};
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_run++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL c%0d %s got %0d exp %0d", cycn, tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_run++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL c%0d %s got %b exp %b", cycn, tag, obs, expv);
    end
  endtask

  // Called on a falling edge: compare, drive next inputs, advance the
  // reference across the coming rising edge, then wait for the next fall.
  task automatic step(input logic rv, input logic ev, input int h, input int s,
                      input int i, input logic [23:0] rgb);
    logic err;
    chk1("RGBoutEn", RGBoutEn, outm.v);
    chk8("R", R, outm.r);
    chk8("G", G, outm.g);
    chk8("B", B, outm.b);
`ifdef HSI2RGB_RANGE_CHECK_EN
    chk1("RangeErr", RangeErr, outm.e);
`endif
    rst     = rv;
    HSIinEn = ev;
    Hin     = 8'(h);
    Sin     = 8'(s);
    Iin     = 8'(i);
    err = (h > 239) || (s > 240) || (i > 240);
    if (rv) begin
      foreach (mline[j]) mline[j].v = 1'b0;
      outm = '0;
    end else begin
      if (mline[5].v) outm = mline[5];
      else begin
        outm.v = 1'b0;
        outm.e = 1'b0;
      end
      for (int j = 5; j > 0; j--) mline[j] = mline[j-1];
      mline[0] = {ev, err, rgb};
    end
    cycn++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 0, 0, 0, 24'd0);
  endtask

  task automatic px_hand(input int h, input int s, input int i,
                         input int r, input int g, input int b);
    step(1'b0, 1'b1, h, s, i, {8'(r), 8'(g), 8'(b)});
  endtask

  task automatic px(input int h, input int s, input int i);
    step(1'b0, 1'b1, h, s, i, model(h, s, i));
  endtask

  initial begin
    int hl [12];
    int sl [4];
    int il [7];
    hl = '{0, 39, 40, 79, 80, 119, 120, 159, 160, 199, 200, 239};
    sl = '{0, 1, 239, 240};
    il = '{0, 1, 119, 120, 121, 239, 240};

    rst = 1'b1; HSIinEn = 1'b0; Hin = 8'd0; Sin = 8'd0; Iin = 8'd0;
    foreach (mline[j]) mline[j] = '0;
    outm = '0;
    repeat (2) @(negedge clk);

    // reset state, then idle
    idle(3);

    // primary hues back to back
    px_hand(0,   240, 120, 255,   0,   0);
    px_hand(40,  240, 120, 255, 255,   0);
    px_hand(80,  240, 120,   0, 255,   0);
    px_hand(120, 240, 120,   0, 255, 255);
    px_hand(160, 240, 120,   0,   0, 255);
    px_hand(200, 240, 120, 255,   0, 255);
    idle(8);

    // interpolation, grey, black, white
    px_hand(20,  240, 120, 255, 128,   0);
    idle(1);
    px_hand(100,   0, 112, 119, 119, 119);
    px_hand(0,     0,   0,   0,   0,   0);
    px_hand(0,   240, 240, 255, 255, 255);
    idle(7);

    // bubble pattern 1,0,1,1,0
    px_hand(60,  120,  60,  64,  96,  32);
    idle(1);
    px_hand(130, 200, 180, 138, 218, 244);
    px_hand(239, 240, 120, 255,   0,   6);
    idle(8);

    // clamping
    px_hand(250, 255, 120, 255,   0,   6);
    px_hand(255, 255, 255, 255, 255, 255);
    px_hand(10,  241,   0,   0,   0,   0);
    idle(7);

    // reset with three pixels in flight
    px(10, 100, 50);
    px(90, 200, 200);
    px(170, 50, 150);
    step(1'b1, 1'b0, 0, 0, 0, 24'd0);
    idle(9);
    px_hand(40, 240, 120, 255, 255, 0);
    idle(7);

    // sector edges against S/I boundaries
    foreach (hl[a]) foreach (sl[b]) foreach (il[c]) px(hl[a], sl[b], il[c]);
    idle(7);

    // random stream with bubbles and occasional out-of-range values
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 4) == 0)
        step(1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), 24'd0);
      else
        px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
